hyperbus_wb_bridge: RTL and testbench

Parametrised Wishbone B3 slave that turns single-word Wishbone reads and writes into HyperBus controller transactions.
- Each Wishbone word is serialised into WB_DATA_WIDTH/HBUS_DATA_WIDTH HyperBus beats, with a command handshake, per-beat byte masks and registered acknowledge.
- Optional transaction timeout reports a stuck controller as a Wishbone error.
- Sits between the system Wishbone interconnect and the HyperBus PHY/controller, in the single wb_clk domain.

---
 rtl/hyperbus_wb_bridge_pkg.sv | 39 +++
 rtl/hyperbus_beat_serdes.sv | 57 +++++
 rtl/hyperbus_wb_bridge.sv | 176 +++++++++++++++++
 tb/tb_hyperbus_wb_bridge.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hyperbus_wb_bridge_pkg.sv
// Shared definitions for the HyperBus Wishbone bridge: one-hot states, mask polarity,
// and the constant helpers used to size the beat datapath.
package hyperbus_pkg;

  localparam int ST_W = 6;

  localparam logic [ST_W-1:0] ST_IDLE  = 6'b000001;
  localparam logic [ST_W-1:0] ST_CMD   = 6'b000010;
  localparam logic [ST_W-1:0] ST_WDATA = 6'b000100;
  localparam logic [ST_W-1:0] ST_RDATA = 6'b001000;
  localparam logic [ST_W-1:0] ST_ACK   = 6'b010000;
  localparam logic [ST_W-1:0] ST_ERR   = 6'b100000;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_CMD   = ST_CMD,
    S_WDATA = ST_WDATA,
    S_RDATA = ST_RDATA,
    S_ACK   = ST_ACK,
    S_ERR   = ST_ERR
  } state_t;

  // Controller mask bit value that means "leave this byte untouched".
  localparam logic MASK_SKIP = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int beats(input int wb_width, input int hbus_width);
    return wb_width / hbus_width;
  endfunction

endpackage

// File: rtl/hyperbus_beat_serdes.sv
// Slices a latched Wishbone word into HyperBus write beats with byte masks, and
// assembles incoming read beats back into the Wishbone read-data register.
module hyperbus_beat_serdes
  import hyperbus_pkg::*;
#(
  parameter int WB_DATA_WIDTH   = 32,
  parameter int HBUS_DATA_WIDTH = 16,
  parameter int IDX_W           = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [WB_DATA_WIDTH-1:0]     i_wdata,
  input  logic [WB_DATA_WIDTH/8-1:0]   i_sel,
  input  logic [IDX_W-1:0]             i_idx,
  input  logic                         i_wr_active,
  input  logic                         i_rd_we,
  input  logic [HBUS_DATA_WIDTH-1:0]   i_rd_beat,
  output logic [HBUS_DATA_WIDTH-1:0]   o_beat,
  output logic [HBUS_DATA_WIDTH/8-1:0] o_mask,
  output logic [WB_DATA_WIDTH-1:0]     o_word
);

  localparam int BEATS    = beats(WB_DATA_WIDTH, HBUS_DATA_WIDTH);
  localparam int HB_BYTES = HBUS_DATA_WIDTH / 8;

  logic [HBUS_DATA_WIDTH-1:0] w_beat;
  logic [HB_BYTES-1:0]        w_sel;
  logic [WB_DATA_WIDTH-1:0]   r_word;

  always_comb begin
    w_beat = '0;
    w_sel  = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (i_idx == IDX_W'(b)) begin
        w_beat = i_wdata[b*HBUS_DATA_WIDTH +: HBUS_DATA_WIDTH];
        w_sel  = i_sel[b*HB_BYTES +: HB_BYTES];
      end
    end
  end

  // Outside a write data phase the beat bus is parked at zero.
  assign o_beat = i_wr_active ? w_beat : '0;
  assign o_mask = i_wr_active ? (w_sel ^ {HB_BYTES{MASK_SKIP}}) : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_word <= '0;
    end else if (i_rd_we) begin
      for (int b = 0; b < BEATS; b++) begin
        if (i_idx == IDX_W'(b)) r_word[b*HBUS_DATA_WIDTH +: HBUS_DATA_WIDTH] <= i_rd_beat;
      end
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/hyperbus_wb_bridge.sv
// Wishbone B3 classic slave that issues one HyperBus command per word and moves it as
// little-endian beats. Define HYPERBUS_WB_TIMEOUT_EN to add the stuck-controller timeout.
module hyperbus_wb_bridge
  import hyperbus_pkg::*;
#(
  parameter int WB_DATA_WIDTH   = 32,
  parameter int WB_ADDR_WIDTH   = 32,
  parameter int HBUS_ADDR_WIDTH = 32,
  parameter int HBUS_DATA_WIDTH = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                         wb_clk,
  input  logic                         wb_rst,
  input  logic [WB_ADDR_WIDTH-1:0]     wb_adr_i,
  input  logic [WB_DATA_WIDTH-1:0]     wb_dat_i,
  input  logic [WB_DATA_WIDTH/8-1:0]   wb_sel_i,
  input  logic                         wb_we_i,
  input  logic                         wb_cyc_i,
  input  logic                         wb_stb_i,
  input  logic [2:0]                   wb_cti_i,
  input  logic [1:0]                   wb_bte_i,
  output logic [WB_DATA_WIDTH-1:0]     wb_dat_o,
  output logic                         wb_ack_o,
  output logic                         wb_err_o,
  output logic                         wb_rty_o,
  output logic [HBUS_ADDR_WIDTH-1:0]   hbus_adr_o,
  output logic [7:0]                   hbus_len_o,
  output logic                         hbus_rrq,
  output logic                         hbus_wrq,
  input  logic                         hbus_ready,
  input  logic                         hbus_busy,
  output logic [HBUS_DATA_WIDTH-1:0]   hbus_dat_o,
  output logic [HBUS_DATA_WIDTH/8-1:0] hbus_mask_o,
  input  logic                         hbus_wnext,
  input  logic [HBUS_DATA_WIDTH-1:0]   hbus_dat_i,
  input  logic                         hbus_valid
);

  localparam int BEATS     = beats(WB_DATA_WIDTH, HBUS_DATA_WIDTH);
  localparam int IDX_W     = (BEATS > 1) ? clog2(BEATS) : 1;
  localparam int ADR_SHIFT = clog2(HBUS_DATA_WIDTH / 8);
  localparam logic [7:0]       LEN      = 8'(BEATS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  state_t                       r_state, w_state_next;
  logic [WB_DATA_WIDTH-1:0]     r_wdat;
  logic [WB_DATA_WIDTH/8-1:0]   r_sel;
  logic                         r_we;
  logic [HBUS_ADDR_WIDTH-1:0]   r_hadr;
  logic [7:0]                   r_len;
  logic [IDX_W-1:0]             r_idx;
  logic                         w_req;
  logic                         w_accept;
  logic                         w_empty_write;
  logic                         w_timeout;

  assign w_req         = wb_cyc_i & wb_stb_i;
  assign w_accept      = (r_state == S_IDLE) & w_req & ~hbus_busy;
  assign w_empty_write = wb_we_i & (wb_sel_i == '0);

`ifdef HYPERBUS_WB_TIMEOUT_EN
  localparam int TO_W = clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            w_active;
  logic            w_progress;

  assign w_active   = (r_state == S_CMD) | (r_state == S_WDATA) | (r_state == S_RDATA);
  assign w_progress = hbus_ready | hbus_wnext | hbus_valid;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_to_cnt <= '0;
    end else if ((w_accept & ~w_empty_write) | w_progress) begin
      r_to_cnt <= '0;
    end else if (w_active) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Fires on the edge where the count would reach TIMEOUT_CYCLES.
  assign w_timeout = w_active & ~w_progress & (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  logic w_unused;
  assign w_unused = ^{wb_cti_i, wb_bte_i};
`else
  assign w_timeout = 1'b0;

  logic w_unused;
  assign w_unused = ^{wb_cti_i, wb_bte_i, TIMEOUT_CYCLES[0]};
`endif

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = w_empty_write ? S_ACK : S_CMD;
      S_CMD: begin
        if (w_timeout)       w_state_next = S_ERR;
        else if (hbus_ready) w_state_next = r_we ? S_WDATA : S_RDATA;
      end
      S_WDATA: begin
        if (w_timeout)                             w_state_next = S_ERR;
        else if (hbus_wnext && r_idx == LAST_IDX) w_state_next = S_ACK;
      end
      S_RDATA: begin
        if (w_timeout)                             w_state_next = S_ERR;
        else if (hbus_valid && r_idx == LAST_IDX) w_state_next = S_ACK;
      end
      S_ACK:   w_state_next = S_IDLE;
      S_ERR:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_wdat <= '0;
      r_sel  <= '0;
      r_we   <= 1'b0;
      r_hadr <= '0;
      r_len  <= '0;
    end else if (w_accept) begin
      r_wdat <= wb_dat_i;
      r_sel  <= wb_sel_i;
      r_we   <= wb_we_i;
      r_hadr <= HBUS_ADDR_WIDTH'(wb_adr_i >> ADR_SHIFT);
      r_len  <= LEN;
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_idx <= '0;
    end else begin
      case (r_state)
        S_CMD:   r_idx <= '0;
        S_WDATA: if (hbus_wnext) r_idx <= r_idx + 1'b1;
        S_RDATA: if (hbus_valid) r_idx <= r_idx + 1'b1;
        default: r_idx <= '0;
      endcase
    end
  end

  hyperbus_beat_serdes #(
    .WB_DATA_WIDTH   (WB_DATA_WIDTH),
    .HBUS_DATA_WIDTH (HBUS_DATA_WIDTH),
    .IDX_W           (IDX_W)
  ) u_serdes (
    .i_clk       (wb_clk),
    .i_rst       (wb_rst),
    .i_wdata     (r_wdat),
    .i_sel       (r_sel),
    .i_idx       (r_idx),
    .i_wr_active (r_state == S_WDATA),
    .i_rd_we     ((r_state == S_RDATA) & hbus_valid),
    .i_rd_beat   (hbus_dat_i),
    .o_beat      (hbus_dat_o),
    .o_mask      (hbus_mask_o),
    .o_word      (wb_dat_o)
  );

  // A master that abandoned the cycle still lets the burst finish but gets no response.
  assign wb_ack_o   = (r_state == S_ACK) & w_req;
  assign wb_err_o   = (r_state == S_ERR) & w_req;
  assign wb_rty_o   = 1'b0;
  assign hbus_rrq   = (r_state == S_CMD) & ~r_we;
  assign hbus_wrq   = (r_state == S_CMD) & r_we;
  assign hbus_adr_o = r_hadr;
  assign hbus_len_o = r_len;

endmodule

// File: tb/tb_hyperbus_wb_bridge.sv
// Directed and randomized bench for hyperbus_wb_bridge acting as both Wishbone master and
// HyperBus controller; expected values come from word/beat arithmetic on each transaction.
module tb_hyperbus_wb_bridge;

  localparam int WBW   = 32;
  localparam int HBW   = 16;
  localparam int BEATS = WBW / HBW;
  localparam int TO    = 8;

  logic          wb_clk = 1'b0;
  logic          wb_rst;
  logic [31:0]   wb_adr_i;
  logic [31:0]   wb_dat_i;
  logic [3:0]    wb_sel_i;
  logic          wb_we_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [2:0]    wb_cti_i;
  logic [1:0]    wb_bte_i;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;
  logic          wb_rty_o;
  logic [31:0]   hbus_adr_o;
  logic [7:0]    hbus_len_o;
  logic          hbus_rrq;
  logic          hbus_wrq;
  logic          hbus_ready;
  logic          hbus_busy;
  logic [15:0]   hbus_dat_o;
  logic [1:0]    hbus_mask_o;
  logic          hbus_wnext;
  logic [15:0]   hbus_dat_i;
  logic          hbus_valid;

  int checks = 0;
  int errors = 0;

  hyperbus_wb_bridge #(
    .WB_DATA_WIDTH   (WBW),
    .WB_ADDR_WIDTH   (32),
    .HBUS_ADDR_WIDTH (32),
    .HBUS_DATA_WIDTH (HBW),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .wb_clk      (wb_clk),
    .wb_rst      (wb_rst),
    .wb_adr_i    (wb_adr_i),
    .wb_dat_i    (wb_dat_i),
    .wb_sel_i    (wb_sel_i),
    .wb_we_i     (wb_we_i),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_cti_i    (wb_cti_i),
    .wb_bte_i    (wb_bte_i),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_o    (wb_ack_o),
    .wb_err_o    (wb_err_o),
    .wb_rty_o    (wb_rty_o),
    .hbus_adr_o  (hbus_adr_o),
    .hbus_len_o  (hbus_len_o),
    .hbus_rrq    (hbus_rrq),
    .hbus_wrq    (hbus_wrq),
    .hbus_ready  (hbus_ready),
    .hbus_busy   (hbus_busy),
    .hbus_dat_o  (hbus_dat_o),
    .hbus_mask_o (hbus_mask_o),
    .hbus_wnext  (hbus_wnext),
    .hbus_dat_i  (hbus_dat_i),
    .hbus_valid  (hbus_valid)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic quiet_inputs();
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = 3'b111; wb_bte_i = 2'b11;
    hbus_ready = 1'b0; hbus_busy = 1'b0; hbus_wnext = 1'b0;
    hbus_dat_i = '0; hbus_valid = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dat_o"}, wb_dat_o, 0);
    check({tag, "_ack"},   {wb_ack_o, wb_err_o, wb_rty_o}, 0);
    check({tag, "_req"},   {hbus_rrq, hbus_wrq}, 0);
    check({tag, "_adr"},   hbus_adr_o, 0);
    check({tag, "_len"},   hbus_len_o, 0);
    check({tag, "_beat"},  {hbus_dat_o, hbus_mask_o}, 0);
  endtask

  // One complete Wishbone access with the bench playing the HyperBus controller.
  task automatic txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input logic [31:0] rd_word,
                     input int busy_cyc, input int rdy_dly, input int gap, input bit drop_cyc);
    logic [31:0] exp_hadr;
    logic [31:0] word_sh;
    logic [3:0]  mask_all;
    logic [3:0]  mask_sh;
    exp_hadr = adr >> 1;
    mask_all = ~sel;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    hbus_busy = (busy_cyc > 0);
    for (int i = 0; i < busy_cyc; i++) begin
      tick();
      check("busy_noreq", {hbus_rrq, hbus_wrq}, 0);
    end
    hbus_busy = 1'b0;
    tick();
    if (we && sel == 4'h0) begin
      check("nosel_noreq", {hbus_rrq, hbus_wrq}, 0);
    end else begin
      for (int c = 0; c <= rdy_dly; c++) begin
        check("cmd_req", {hbus_rrq, hbus_wrq}, we ? 2'b01 : 2'b10);
        check("cmd_adr", hbus_adr_o, exp_hadr);
        check("cmd_len", hbus_len_o, BEATS - 1);
        if (c == rdy_dly) hbus_ready = 1'b1;
        tick();
        hbus_ready = 1'b0;
      end
      check("req_drop", {hbus_rrq, hbus_wrq}, 0);
      for (int k = 0; k < BEATS; k++) begin
        word_sh = (we ? dat : rd_word) >> (HBW * k);
        mask_sh = mask_all >> (2 * k);
        for (int g = 0; g <= gap; g++) begin
          if (we) begin
            check("wbeat_dat", hbus_dat_o, word_sh[15:0]);
            check("wbeat_mask", hbus_mask_o, mask_sh[1:0]);
          end
          if (g == gap) begin
            if (we) hbus_wnext = 1'b1;
            else begin hbus_valid = 1'b1; hbus_dat_i = word_sh[15:0]; end
          end
          tick();
          hbus_wnext = 1'b0; hbus_valid = 1'b0; hbus_dat_i = $urandom;
        end
        if (drop_cyc && k == 0) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
      end
      if (!we) check("rd_word", wb_dat_o, rd_word);
    end
    check("ack", wb_ack_o, !drop_cyc);
    check("err_idle", wb_err_o, 0);
    tick();
    check("ack_once", wb_ack_o, 0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  initial begin
    int n_wrq;
    int n_err;
    int n_ack;
    quiet_inputs();
    wb_rst = 1'b1;
    tick();
    tick();
    check_outputs_zero("reset");
    wb_rst = 1'b0;
    tick();

    txn(1'b1, 32'h100, 32'hA1B2_C3D4, 4'hF, 32'h0, 0, 2, 0, 1'b0);
    txn(1'b0, 32'h204, 32'h0, 4'hF, 32'h1234_5678, 0, 0, 3, 1'b0);
    txn(1'b1, 32'h300, 32'hDEAD_BEEF, 4'b0100, 32'h0, 0, 1, 1, 1'b0);
    txn(1'b1, 32'h400, 32'h5555_AAAA, 4'b0000, 32'h0, 0, 0, 0, 1'b0);
    txn(1'b0, 32'h50C, 32'h0, 4'hF, 32'hCAFE_F00D, 5, 1, 0, 1'b0);
    txn(1'b0, 32'h610, 32'h0, 4'hF, 32'h0BAD_1DEA, 0, 0, 1, 1'b1);
    txn(1'b0, 32'h714, 32'h0, 4'hF, 32'h7654_3210, 0, 0, 0, 1'b0);

    // Reset while the first write beat is on the bus.
    wb_adr_i = 32'h800; wb_dat_i = 32'h1357_9BDF; wb_sel_i = 4'hF; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    tick();
    hbus_ready = 1'b1;
    tick();
    hbus_ready = 1'b0;
    check("pre_rst_beat", hbus_dat_o, 16'h9BDF);
    #1 wb_rst = 1'b1;
    #1 check_outputs_zero("midrst");
    quiet_inputs();
    tick();
    wb_rst = 1'b0;
    tick();
    txn(1'b0, 32'h904, 32'h0, 4'hF, 32'h2468_ACE0, 0, 1, 0, 1'b0);

`ifdef HYPERBUS_WB_TIMEOUT_EN
    n_wrq = 0; n_err = 0; n_ack = 0;
    wb_adr_i = 32'hA00; wb_dat_i = 32'h1111_2222; wb_sel_i = 4'hF; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    tick();
    for (int i = 0; i < 40; i++) begin
      if (hbus_wrq) n_wrq++;
      if (wb_ack_o) n_ack++;
      if (wb_err_o) begin
        n_err++;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      end
      tick();
    end
    quiet_inputs();
    check("to_wrq_cycles", n_wrq, TO);
    check("to_err_pulses", n_err, 1);
    check("to_no_ack", n_ack, 0);
`else
    n_wrq = 0; n_err = 0; n_ack = 0;
`endif

    for (int t = 0; t < 24; t++) begin
      logic        r_we;
      logic [3:0]  r_sel;
      r_we  = 1'($urandom_range(0, 1));
      r_sel = 4'($urandom_range(0, 15));
      txn(r_we, $urandom, $urandom, r_sel, $urandom,
          $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
      check("rand_err_quiet", wb_err_o, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
